// File: rtl/sequenciador_ula_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sequenciador_ula_pkg : opcodes, FSM states and instruction field positions |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package sequenciador_ula_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_NOT = 3'b100,
        OP_MOV = 3'b101,
        OP_LDI = 3'b110,
        OP_NOP = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        BUSCA   = 2'b01,
        EXECUTA = 2'b10,
        ESCRITA = 2'b11
    } estado_t;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int RS2_MSB = 2;
    localparam int RS2_LSB = 1;

    // Opcodes 000..100 are the ones whose result comes from the external ALU.
    function automatic logic usa_ula(input opcode_t op);
        return (op <= OP_NOT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sequenciador_ula_banco_registradores.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | banco_registradores : 4-entry register file, 1 write / 3 read ports        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module banco_registradores #(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               escrita_en,
    input  logic [1:0]         escrita_sel,
    input  logic [LARGURA-1:0] escrita_dado,
    input  logic [1:0]         rd_sel,
    output logic [LARGURA-1:0] rd_dado,
    input  logic [1:0]         rs2_sel,
    output logic [LARGURA-1:0] rs2_dado,
    input  logic [1:0]         leitura_sel,
    output logic [LARGURA-1:0] leitura_dado
);

    logic [LARGURA-1:0] r_reg [4];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_reg[i] <= '0;
            end
        end else if (escrita_en) begin
            r_reg[escrita_sel] <= escrita_dado;
        end
    end

    assign rd_dado      = r_reg[rd_sel];
    assign rs2_dado     = r_reg[rs2_sel];
    assign leitura_dado = r_reg[leitura_sel];

endmodule
`default_nettype wire

// File: rtl/sequenciador_ula.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sequenciador_ula : 4-state sequencer driving an external combinational ALU |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sequenciador_ula
    import sequenciador_ula_pkg::*;
#(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               instr_valido,
    output logic               instr_pronto,
    input  logic [7:0]         instrucao,
    input  logic [LARGURA-1:0] imediato,
    output logic [LARGURA-1:0] entrada1,
    output logic [LARGURA-1:0] entrada2,
    output logic [2:0]         operacao,
    input  logic [LARGURA-1:0] resultado,
    input  logic               carryout,
    output logic               flag_zero,
    output logic               flag_carry,
    output logic               concluido,
    input  logic [1:0]         leitura_sel,
    output logic [LARGURA-1:0] leitura_dado
);

    estado_t            r_estado;
    opcode_t            r_opcode;
    logic [1:0]         r_rd;
    logic [1:0]         r_rs2;
    logic [LARGURA-1:0] r_imediato;
    logic [LARGURA-1:0] r_resultado;
    logic               r_carry;

    logic [LARGURA-1:0] w_dado_rd;
    logic [LARGURA-1:0] w_dado_rs2;
    logic               w_escrita_en;
    logic               w_unused_bit0;

    assign instr_pronto  = (r_estado == OCIOSO);
    assign w_escrita_en  = (r_estado == ESCRITA) && (r_opcode != OP_NOP);
    assign w_unused_bit0 = instrucao[0];

    banco_registradores #(
        .LARGURA (LARGURA)
    ) u_banco (
        .clock        (clock),
        .reset_n      (reset_n),
        .escrita_en   (w_escrita_en),
        .escrita_sel  (r_rd),
        .escrita_dado (r_resultado),
        .rd_sel       (r_rd),
        .rd_dado      (w_dado_rd),
        .rs2_sel      (r_rs2),
        .rs2_dado     (w_dado_rs2),
        .leitura_sel  (leitura_sel),
        .leitura_dado (leitura_dado)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado    <= OCIOSO;
            r_opcode    <= OP_AND;
            r_rd        <= '0;
            r_rs2       <= '0;
            r_imediato  <= '0;
            r_resultado <= '0;
            r_carry     <= 1'b0;
            entrada1    <= '0;
            entrada2    <= '0;
            operacao    <= 3'b000;
            flag_zero   <= 1'b0;
            flag_carry  <= 1'b0;
            concluido   <= 1'b0;
        end else begin
            concluido <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (instr_valido) begin
                        r_opcode   <= opcode_t'(instrucao[OPC_MSB:OPC_LSB]);
                        r_rd       <= instrucao[RD_MSB:RD_LSB];
                        r_rs2      <= instrucao[RS2_MSB:RS2_LSB];
                        r_imediato <= imediato;
                        r_estado   <= BUSCA;
                    end
                end
                BUSCA: begin
                    if (usa_ula(r_opcode)) begin
                        entrada1 <= w_dado_rd;
                        entrada2 <= w_dado_rs2;
                        operacao <= r_opcode;
                    end else begin
                        operacao <= 3'b000;
                    end
                    r_estado <= EXECUTA;
                end
                EXECUTA: begin
                    case (r_opcode)
                        OP_MOV:  r_resultado <= w_dado_rs2;
                        OP_LDI:  r_resultado <= r_imediato;
                        default: r_resultado <= resultado;
                    endcase
                    r_carry   <= ((r_opcode == OP_ADD) || (r_opcode == OP_SUB)) ? carryout : 1'b0;
                    // Registered so the pulse lines up with the ESCRITA cycle.
                    concluido <= 1'b1;
                    r_estado  <= ESCRITA;
                end
                ESCRITA: begin
                    if (r_opcode != OP_NOP) begin
                        flag_zero  <= (r_resultado == '0);
                        flag_carry <= r_carry;
                    end
                    r_estado <= OCIOSO;
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_ula.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sequenciador_ula : randomized bench with behavioural ISA reference model|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sequenciador_ula;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       instr_valido;
    logic       instr_pronto;
    logic [7:0] instrucao;
    logic [7:0] imediato;
    logic [7:0] entrada1;
    logic [7:0] entrada2;
    logic [2:0] operacao;
    logic [7:0] resultado;
    logic       carryout;
    logic       flag_zero;
    logic       flag_carry;
    logic       concluido;
    logic [1:0] leitura_sel;
    logic [7:0] leitura_dado;

    int erros = 0;
    int total = 0;

    logic [7:0] m_reg [4];
    logic       m_z;
    logic       m_c;

    always #5 clock = ~clock;

    sequenciador_ula #(
        .LARGURA (8)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .instr_valido (instr_valido),
        .instr_pronto (instr_pronto),
        .instrucao    (instrucao),
        .imediato     (imediato),
        .entrada1     (entrada1),
        .entrada2     (entrada2),
        .operacao     (operacao),
        .resultado    (resultado),
        .carryout     (carryout),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
        .concluido    (concluido),
        .leitura_sel  (leitura_sel),
        .leitura_dado (leitura_dado)
    );

    // External ALU; carry is deliberately 1 for logic ops so a leak into the flag shows up.
    logic [8:0] w_soma;
    always_comb begin
        w_soma    = {1'b0, entrada1} + {1'b0, entrada2};
        resultado = 8'h00;
        carryout  = 1'b1;
        case (operacao)
            3'd0: resultado = entrada1 & entrada2;
            3'd1: resultado = entrada1 | entrada2;
            3'd2: begin resultado = w_soma[7:0]; carryout = w_soma[8]; end
            3'd3: begin resultado = entrada1 - entrada2; carryout = (entrada1 < entrada2); end
            3'd4: resultado = ~entrada1;
            default: resultado = 8'h00;
        endcase
    end

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs !== esp) begin
            erros++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic modelo_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_z = 1'b0;
        m_c = 1'b0;
    endtask

    task automatic modelo(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs2,
                          input logic [7:0] imm);
        int a, b, r;
        logic c;
        a = int'(m_reg[rd]);
        b = int'(m_reg[rs2]);
        c = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin r = (a + b) % 256; c = (a + b) > 255; end
            3'd3: begin r = (a - b + 256) % 256; c = a < b; end
            3'd4: r = 255 - a;
            3'd5: r = b;
            3'd6: r = int'(imm);
            default: r = -1;
        endcase
        if (op != 3'd7) begin
            m_reg[rd] = 8'(r);
            m_z = (r == 0);
            m_c = c;
        end
    endtask

    task automatic confere_estado(input string tag);
        for (int i = 0; i < 4; i++) begin
            leitura_sel = 2'(i);
            #1;
            verifica($sformatf("%s_R%0d", tag, i), leitura_dado, m_reg[i]);
        end
        verifica({tag, "_z"}, flag_zero, m_z);
        verifica({tag, "_c"}, flag_carry, m_c);
    endtask

    task automatic executa_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs2,
                                 input logic [7:0] imm);
        int n;
        n = 0;
        while (!instr_pronto && n < 8) begin
            @(negedge clock);
            n++;
        end
        verifica("pronto", instr_pronto, 1'b1);
        instrucao    = {op, rd, rs2, 1'($urandom)};
        imediato     = imm;
        instr_valido = 1'b1;
        @(negedge clock);
        instr_valido = 1'b0;
        instrucao    = 8'($urandom);
        imediato     = 8'($urandom);
        modelo(op, rd, rs2, imm);
        n = 1;
        while (!concluido && n < 8) begin
            @(negedge clock);
            n++;
        end
        verifica("latencia", n, 3);
        @(negedge clock);
        verifica("pulso", concluido, 1'b0);
        verifica("pronto_pos", instr_pronto, 1'b1);
        confere_estado($sformatf("op%0d", op));
    endtask

    logic [2:0] q_op  [3];
    logic [1:0] q_rd  [3];
    logic [1:0] q_rs2 [3];
    logic [7:0] q_imm [3];

    initial begin
        int aceitos, feitos, ciclos, extra;
        logic aceita;

        reset_n      = 1'b0;
        instr_valido = 1'b0;
        instrucao    = 8'h00;
        imediato     = 8'h00;
        leitura_sel  = 2'd0;
        modelo_reset();

        // Reset behaviour
        @(negedge clock);
        verifica("rst_pronto", instr_pronto, 1'b1);
        @(negedge clock);
        verifica("rst_concl", concluido, 1'b0);
        verifica("rst_e1", entrada1, 8'h00);
        verifica("rst_e2", entrada2, 8'h00);
        verifica("rst_op", operacao, 3'b000);
        reset_n = 1'b1;
        @(negedge clock);
        verifica("rst_pronto2", instr_pronto, 1'b1);
        confere_estado("rst");

        // Directed sequences
        executa_instr(3'd6, 2'd1, 2'd0, 8'h0F);
        executa_instr(3'd6, 2'd2, 2'd0, 8'h3C);
        executa_instr(3'd0, 2'd1, 2'd2, 8'h00);
        executa_instr(3'd6, 2'd1, 2'd0, 8'hF0);
        executa_instr(3'd6, 2'd2, 2'd0, 8'h0F);
        executa_instr(3'd0, 2'd1, 2'd2, 8'h00);
        executa_instr(3'd7, 2'd1, 2'd2, 8'h55);
        executa_instr(3'd6, 2'd1, 2'd0, 8'hFF);
        executa_instr(3'd6, 2'd2, 2'd0, 8'h01);
        executa_instr(3'd2, 2'd1, 2'd2, 8'h00);
        executa_instr(3'd7, 2'd0, 2'd0, 8'h00);
        executa_instr(3'd6, 2'd3, 2'd0, 8'h05);
        executa_instr(3'd6, 2'd0, 2'd0, 8'h03);
        executa_instr(3'd3, 2'd3, 2'd0, 8'h00);
        executa_instr(3'd3, 2'd0, 2'd3, 8'h00);
        executa_instr(3'd4, 2'd2, 2'd2, 8'h00);
        executa_instr(3'd5, 2'd1, 2'd3, 8'h00);
        executa_instr(3'd2, 2'd3, 2'd3, 8'h00);

        // Random instruction stream
        for (int k = 0; k < 40; k++) begin
            executa_instr(3'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
        end

        // Instr_valido held high across three queued instructions
        q_op[0] = 3'd6; q_rd[0] = 2'd3; q_rs2[0] = 2'd0; q_imm[0] = 8'h41;
        q_op[1] = 3'd2; q_rd[1] = 2'd3; q_rs2[1] = 2'd3; q_imm[1] = 8'hAA;
        q_op[2] = 3'd3; q_rd[2] = 2'd2; q_rs2[2] = 2'd3; q_imm[2] = 8'h77;
        aceitos = 0;
        feitos  = 0;
        ciclos  = 0;
        instrucao    = {q_op[0], q_rd[0], q_rs2[0], 1'b1};
        imediato     = q_imm[0];
        instr_valido = 1'b1;
        while (feitos < 3 && ciclos < 40) begin
            aceita = instr_pronto && instr_valido;
            @(negedge clock);
            ciclos++;
            if (aceita) begin
                modelo(q_op[aceitos], q_rd[aceitos], q_rs2[aceitos], q_imm[aceitos]);
                aceitos++;
                if (aceitos < 3) begin
                    instrucao = {q_op[aceitos], q_rd[aceitos], q_rs2[aceitos], 1'b0};
                    imediato  = q_imm[aceitos];
                end else begin
                    instr_valido = 1'b0;
                end
            end
            if (concluido) feitos++;
        end
        verifica("fila_ciclos", ciclos, 11);
        verifica("fila_aceitos", aceitos, 3);
        @(negedge clock);
        confere_estado("fila");
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (concluido) extra++;
        end
        verifica("fila_extra", extra, 0);

        // Reset during EXECUTA of an ADD
        executa_instr(3'd6, 2'd1, 2'd0, 8'hFF);
        executa_instr(3'd6, 2'd2, 2'd0, 8'h01);
        instrucao    = {3'd2, 2'd1, 2'd2, 1'b0};
        instr_valido = 1'b1;
        @(negedge clock);
        instr_valido = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        verifica("mid_pronto", instr_pronto, 1'b1);
        verifica("mid_concl", concluido, 1'b0);
        @(negedge clock);
        verifica("mid_concl2", concluido, 1'b0);
        reset_n = 1'b1;
        modelo_reset();
        @(negedge clock);
        verifica("mid_concl3", concluido, 1'b0);
        verifica("mid_pronto2", instr_pronto, 1'b1);
        confere_estado("mid");
        executa_instr(3'd6, 2'd0, 2'd0, 8'h9C);

        $display("Result: errors=%0d of %0d checks", erros, total);
        $finish;
    end

endmodule
`default_nettype wire
